cal_avg_fifo_ctrl: RTL and testbench
====================================

Name: cal_avg_fifo_ctrl

Overview:
- Synchronous FIFO controller for the calibrator averaging path.
- Owns the write/read pointers, occupancy count and status flags, and drives the write/read ports of the uSRAM-based RAM wrapper directly downstream of it.
- Realigns the wrapper's pipelined read data with a valid strobe.
- Single clock domain; the averaging engine writes to it and the output packer reads from it.

Parameters:
- WIDTH, 32: data word width; must equal the RAM wrapper data width.
- DEPTH, 128: number of words; must be a power of two.
- AW, 7: address width, log2(DEPTH).
- RD_LAT, 2: RAM read latency in clocks, from the accepted-read edge to RAM_RDATA valid (address register plus pipelined output register).
- AFULL_TH, 120: AFULL asserts when COUNT >= AFULL_TH.
- AEMPTY_TH, 8: AEMPTY asserts when COUNT <= AEMPTY_TH.

Ports:
- CLOCK  in  1  system clock; all logic is rising-edge.
- RESET  in  1  asynchronous reset, active-high.
- SCLR  in  1  synchronous flush: empties the FIFO and drops in-flight reads.
- WE  in  1  write request.
- DATA  in  WIDTH  write data.
- RE  in  1  read request.
- Q  out  WIDTH  read data; held between valid strobes.
- Q_VALID  out  1  Q is new this cycle.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- AFULL  out  1  almost full.
- AEMPTY  out  1  almost empty.
- COUNT  out  AW+1  occupancy.
- OVERFLOW  out  1  one-cycle pulse: WE was asserted while FULL.
- UNDERFLOW  out  1  one-cycle pulse: RE was asserted while EMPTY.
- RAM_WADDR  out  AW  to wrapper WADDR.
- RAM_WDATA  out  WIDTH  to wrapper WDATA.
- RAM_WEN  out  1  to wrapper WEN.
- RAM_RADDR  out  AW  to wrapper RADDR.
- RAM_REN  out  1  to wrapper REN.
- RAM_RDATA  in  WIDTH  from wrapper RDATA.
- RAM_RESET_N  out  1  to wrapper RESET_N; equals ~RESET.

Behaviour:
- Reset (RESET=1, asynchronous):
  - wptr = rptr = 0, COUNT = 0, EMPTY = 1, AEMPTY = 1.
  - FULL = 0, AFULL = 0, Q = 0, Q_VALID = 0, OVERFLOW = 0, UNDERFLOW = 0.
  - Valid shift register cleared.
- Accept rules (evaluated on flags registered at the start of the cycle):
  - wr_ok = WE & ~FULL.
  - rd_ok = RE & ~EMPTY.
- Write path:
  - RAM_WEN = wr_ok, RAM_WADDR = wptr, RAM_WDATA = DATA (combinational).
  - wptr increments on wr_ok and wraps modulo DEPTH.
- Read path:
  - RAM_REN = rd_ok, RAM_RADDR = rptr (combinational).
  - rptr increments on rd_ok and wraps modulo DEPTH.
  - rd_ok enters an RD_LAT-deep valid shift register.
  - When the shift register output is 1, Q <= RAM_RDATA and Q_VALID = 1 on the following cycle.
  - Total RE-to-Q_VALID latency: RD_LAT+1 clocks.
- COUNT update:
  - +1 on wr_ok & ~rd_ok.
  - -1 on rd_ok & ~wr_ok.
  - Unchanged when both or neither are accepted.
  - All flags are registered and derived from the next COUNT, so they are valid in the same cycle as COUNT.
- Simultaneous events:
  - Write while FULL is rejected even if a read is accepted that cycle (no pass-through); OVERFLOW pulses.
  - Read while EMPTY is rejected even if a write is accepted that cycle; UNDERFLOW pulses.
  - Both requests accepted when 0 < COUNT < DEPTH: COUNT is unchanged.
- Read-after-write: a word written in cycle t is readable from cycle t+1. The RAM commits the write at edge t, before the read address registers at edge t+1.
- SCLR:
  - Synchronous; has priority over WE and RE in the same cycle.
  - Pointers and COUNT go to 0 and the valid shift register is cleared, so no Q_VALID appears for flushed reads.
  - Q holds its value.
  - RAM contents are not cleared.
- Reset asserted mid-operation: everything returns to reset values asynchronously and all in-flight reads are discarded.
- Arithmetic: COUNT is unsigned AW+1 bits and never exceeds DEPTH; pointers are AW bits with natural wrap.

Test Plan:
- Reset, then write 0x00000001..0x00000004 on consecutive cycles, then RE for 4 cycles:
  - COUNT goes 1,2,3,4 then back to 0.
  - Q_VALID is asserted 3 clocks after each RE, with Q = 1,2,3,4 in order.
  - EMPTY = 1 at the end.
- Write 128 words (data = index):
  - FULL = 1 and COUNT = 128; AFULL rises when COUNT reaches 120.
  - A 129th WE produces a one-cycle OVERFLOW pulse and leaves COUNT = 128.
  - Reading all 128 words returns 0..127.
- Pointer wrap: repeat 300 interleaved write/read pairs (FIFO kept at 5 words) → data order preserved across wrap, COUNT stays at 5, no flag glitches.
- FULL with WE and RE in the same cycle: read accepted, write rejected, OVERFLOW = 1, COUNT = 127. With COUNT = 5 and both asserted: COUNT stays 5.
- EMPTY with RE and WE in the same cycle: UNDERFLOW = 1, write accepted, COUNT = 1. The next-cycle read returns the written word.
- SCLR asserted one cycle after two RE accepts with COUNT = 10:
  - COUNT = 0 and EMPTY = 1 on the next cycle; no Q_VALID for the flushed reads.
  - RESET pulsed mid-burst returns all outputs to reset values.

Source files
------------

// File: rtl/cal_avg_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// cal_avg_fifo_ctrl
//
// Synchronous FIFO controller for the calibrator averaging path. The averaging
// engine writes and the output packer reads. This block owns the pointers, the
// occupancy count and the status flags. It drives the write and read ports of
// the uSRAM-based RAM wrapper directly. A valid shift register realigns the
// wrapper's pipelined read data with Q_VALID.
//
// Ports
//   CLOCK        system clock, rising edge
//   RESET        asynchronous reset, active-high
//   SCLR         synchronous flush: pointers, COUNT and in-flight reads cleared
//   WE / DATA    write request and write word
//   RE           read request
//   Q / Q_VALID  read word (held between strobes) and its one-cycle strobe
//   FULL, EMPTY, AFULL, AEMPTY, COUNT
//                registered status, all derived from the next COUNT
//   OVERFLOW     one-cycle pulse: WE while FULL
//   UNDERFLOW    one-cycle pulse: RE while EMPTY
//   RAM_*        wrapper write/read ports (RAM_RDATA arrives RD_LAT clocks
//                after an accepted read); RAM_RESET_N = ~RESET
// -----------------------------------------------------------------------------
module cal_avg_fifo_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 128,
    parameter int AW        = 7,
    parameter int RD_LAT    = 2,
    parameter int AFULL_TH  = 120,
    parameter int AEMPTY_TH = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             SCLR,
    input  logic             WE,
    input  logic [WIDTH-1:0] DATA,
    input  logic             RE,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    output logic             FULL,
    output logic             EMPTY,
    output logic             AFULL,
    output logic             AEMPTY,
    output logic [AW:0]      COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW,
    output logic [AW-1:0]    RAM_WADDR,
    output logic [WIDTH-1:0] RAM_WDATA,
    output logic             RAM_WEN,
    output logic [AW-1:0]    RAM_RADDR,
    output logic             RAM_REN,
    input  logic [WIDTH-1:0] RAM_RDATA,
    output logic             RAM_RESET_N
);

    localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AFULL  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0]   CNT_AEMPTY = (AW+1)'(AEMPTY_TH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d;
    logic              full_q, empty_q, afull_q, aempty_q;
    logic              ovf_q, unf_q;
    logic [WIDTH-1:0]  q_q;
    logic              qv_q, qv_d;
    logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;

    logic wr_ok;
    logic rd_ok;
    logic vld_out;

    // Accept decisions use the flags registered at the start of the cycle.
    // A flush overrides both requests, so nothing is written or read that cycle.
    assign wr_ok   = WE & ~full_q  & ~SCLR;
    assign rd_ok   = RE & ~empty_q & ~SCLR;
    assign vld_out = vld_sr_q[RD_LAT-1];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (SCLR) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_ok) wptr_d = wptr_q + PTR_ONE;
            if (rd_ok) rptr_d = rptr_q + PTR_ONE;
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Valid shift register tracks accepted reads through the RAM pipeline.
    always_comb begin
        vld_sr_d    = '0;
        vld_sr_d[0] = rd_ok;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end
        if (SCLR) vld_sr_d = '0;
    end

    // Reads still in flight at a flush must not surface on Q.
    assign qv_d = vld_out & ~SCLR;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            q_q      <= '0;
            qv_q     <= 1'b0;
            vld_sr_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= CNT_AFULL);
            aempty_q <= (count_d <= CNT_AEMPTY);
            ovf_q    <= WE & full_q  & ~SCLR;
            unf_q    <= RE & empty_q & ~SCLR;
            vld_sr_q <= vld_sr_d;
            qv_q     <= qv_d;
            if (qv_d) q_q <= RAM_RDATA;
        end
    end

    assign RAM_WEN     = wr_ok;
    assign RAM_WADDR   = wptr_q;
    assign RAM_WDATA   = DATA;
    assign RAM_REN     = rd_ok;
    assign RAM_RADDR   = rptr_q;
    assign RAM_RESET_N = ~RESET;

    assign Q         = q_q;
    assign Q_VALID   = qv_q;
    assign FULL      = full_q;
    assign EMPTY     = empty_q;
    assign AFULL     = afull_q;
    assign AEMPTY    = aempty_q;
    assign COUNT     = count_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_cal_avg_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cal_avg_fifo_ctrl
//
// Directed bench for cal_avg_fifo_ctrl with a behavioural two-stage RAM model
// (address register, then output register) standing in for the uSRAM wrapper.
// -----------------------------------------------------------------------------
module tb_cal_avg_fifo_ctrl;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 128;
    localparam int AW     = 7;
    localparam int RD_LAT = 2;

    logic             CLOCK;
    logic             RESET;
    logic             SCLR;
    logic             WE;
    logic [WIDTH-1:0] DATA;
    logic             RE;
    logic [WIDTH-1:0] Q;
    logic             Q_VALID;
    logic             FULL;
    logic             EMPTY;
    logic             AFULL;
    logic             AEMPTY;
    logic [AW:0]      COUNT;
    logic             OVERFLOW;
    logic             UNDERFLOW;
    logic [AW-1:0]    RAM_WADDR;
    logic [WIDTH-1:0] RAM_WDATA;
    logic             RAM_WEN;
    logic [AW-1:0]    RAM_RADDR;
    logic             RAM_REN;
    logic [WIDTH-1:0] RAM_RDATA;
    logic             RAM_RESET_N;

    int checks = 0;
    int errors = 0;

    cal_avg_fifo_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .RD_LAT(RD_LAT),
        .AFULL_TH(120), .AEMPTY_TH(8)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .SCLR(SCLR), .WE(WE), .DATA(DATA),
        .RE(RE), .Q(Q), .Q_VALID(Q_VALID), .FULL(FULL), .EMPTY(EMPTY),
        .AFULL(AFULL), .AEMPTY(AEMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
        .UNDERFLOW(UNDERFLOW), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA),
        .RAM_WEN(RAM_WEN), .RAM_RADDR(RAM_RADDR), .RAM_REN(RAM_REN),
        .RAM_RDATA(RAM_RDATA), .RAM_RESET_N(RAM_RESET_N)
    );

    // RAM wrapper model: write commits at the edge, read address registers at
    // the accepted-read edge, output register loads one edge later.
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    ram_raddr_q;

    always @(posedge CLOCK) begin
        if (RAM_WEN) mem[RAM_WADDR] <= RAM_WDATA;
        if (RAM_REN) ram_raddr_q <= RAM_RADDR;
        RAM_RDATA <= mem[ram_raddr_q];
    end

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold RE for n cycles and expect the words first, first+1, ... to appear
    // RD_LAT+1 clocks after each request, followed by Q_VALID low.
    task automatic read_burst(input int n, input logic [31:0] first);
        for (int c = 0; c < n + RD_LAT + 1; c++) begin
            RE = (c < n);
            tick();
            if (c >= RD_LAT) begin
                if (c - RD_LAT < n) begin
                    check("burst_qvalid", Q_VALID, 1);
                    check("burst_q", Q, first + 32'(c - RD_LAT));
                end else begin
                    check("burst_qvalid_end", Q_VALID, 0);
                end
            end
        end
        RE = 1'b0;
    endtask

    initial begin
        RESET = 1'b0; SCLR = 1'b0; WE = 1'b0; RE = 1'b0; DATA = '0;
        #1 RESET = 1'b1;
        #1;
        // ---------------- reset values
        check("rst_count", COUNT, 0);
        check("rst_flags", {FULL, EMPTY, AFULL, AEMPTY}, 4'b0101);
        check("rst_q", Q, 0);
        check("rst_pulses", {Q_VALID, OVERFLOW, UNDERFLOW}, 3'b000);
        check("rst_ram_reset_n", RAM_RESET_N, 0);
        tick(); tick();
        RESET = 1'b0;
        tick();
        check("rst_release_ram_reset_n", RAM_RESET_N, 1);

        // ---------------- write 1..4, read back
        for (int i = 0; i < 4; i++) begin
            WE = 1'b1; DATA = 32'(i + 1);
            tick();
            check("t1_count_up", COUNT, i + 1);
        end
        WE = 1'b0;
        check("t1_empty_low", EMPTY, 0);
        read_burst(4, 32'd1);
        check("t1_count_end", COUNT, 0);
        check("t1_empty_end", EMPTY, 1);

        // ---------------- fill 128, overflow, drain
        for (int i = 0; i < DEPTH; i++) begin
            WE = 1'b1; DATA = 32'(i);
            tick();
            check("t2_count", COUNT, i + 1);
            check("t2_afull", AFULL, (i + 1 >= 120) ? 1 : 0);
            check("t2_full", FULL, (i + 1 == DEPTH) ? 1 : 0);
        end
        DATA = 32'd999;
        #1;
        check("t2_wen_blocked", RAM_WEN, 0);
        tick();
        check("t2_overflow", OVERFLOW, 1);
        check("t2_count_full", COUNT, 128);
        WE = 1'b0;
        tick();
        check("t2_overflow_pulse_end", OVERFLOW, 0);
        read_burst(DEPTH, 32'd0);
        check("t2_empty", {EMPTY, AEMPTY, COUNT}, {1'b1, 1'b1, 8'd0});

        // ---------------- pointer wrap with 5 words resident
        for (int i = 0; i < 5; i++) begin
            WE = 1'b1; DATA = 32'(1000 + i);
            tick();
        end
        for (int c = 0; c < 300; c++) begin
            WE = 1'b1; RE = 1'b1; DATA = 32'(1005 + c);
            tick();
            check("t3_count", COUNT, 5);
            check("t3_flags", {FULL, EMPTY, AFULL, AEMPTY}, 4'b0001);
            if (c >= RD_LAT) begin
                check("t3_qvalid", Q_VALID, 1);
                check("t3_q", Q, 32'(1000 + c - RD_LAT));
            end
        end
        WE = 1'b0; RE = 1'b0;
        tick();
        check("t3_tail0", Q, 32'd1298);
        tick();
        check("t3_tail1", Q, 32'd1299);
        read_burst(5, 32'd1300);

        // ---------------- FULL with WE and RE together
        for (int i = 0; i < DEPTH; i++) begin
            WE = 1'b1; DATA = 32'(2000 + i);
            tick();
        end
        check("t4_full", FULL, 1);
        RE = 1'b1; DATA = 32'hDEAD;
        #1;
        check("t4_wen_blocked", RAM_WEN, 0);
        check("t4_ren", RAM_REN, 1);
        tick();
        check("t4_overflow", OVERFLOW, 1);
        check("t4_count", COUNT, 127);
        check("t4_flags", {FULL, AFULL}, 2'b01);
        WE = 1'b0; RE = 1'b0;
        tick();
        check("t4_overflow_end", OVERFLOW, 0);
        tick();
        check("t4_first_q", {Q_VALID, Q}, {1'b1, 32'd2000});
        read_burst(127, 32'd2001);

        // ---------------- COUNT = 5 with both requests
        for (int i = 0; i < 5; i++) begin
            WE = 1'b1; DATA = 32'(4000 + i);
            tick();
        end
        RE = 1'b1; DATA = 32'd4005;
        tick();
        check("t4b_count", COUNT, 5);
        WE = 1'b0; RE = 1'b0;
        tick(); tick();
        check("t4b_q", {Q_VALID, Q}, {1'b1, 32'd4000});
        read_burst(5, 32'd4001);

        // ---------------- EMPTY with RE and WE together
        WE = 1'b1; RE = 1'b1; DATA = 32'h55;
        #1;
        check("t5_ren_blocked", RAM_REN, 0);
        check("t5_wen", RAM_WEN, 1);
        tick();
        check("t5_underflow", UNDERFLOW, 1);
        check("t5_count", COUNT, 1);
        check("t5_empty", EMPTY, 0);
        WE = 1'b0;
        tick();
        check("t5_underflow_end", UNDERFLOW, 0);
        check("t5_count_after_read", COUNT, 0);
        RE = 1'b0;
        tick();
        check("t5_no_valid_rejected", Q_VALID, 0);
        tick();
        check("t5_q", {Q_VALID, Q}, {1'b1, 32'h55});

        // ---------------- SCLR with reads in flight
        for (int i = 0; i < 10; i++) begin
            WE = 1'b1; DATA = 32'(3000 + i);
            tick();
        end
        WE = 1'b0;
        check("t6_count10", COUNT, 10);
        RE = 1'b1;
        tick(); tick();
        check("t6_count8", COUNT, 8);
        RE = 1'b0; SCLR = 1'b1;
        tick();
        check("t6_flush_count", COUNT, 0);
        check("t6_flush_empty", EMPTY, 1);
        check("t6_flush_qv0", Q_VALID, 0);
        SCLR = 1'b0;
        tick();
        check("t6_flush_qv1", Q_VALID, 0);
        tick();
        check("t6_flush_qv2", Q_VALID, 0);
        check("t6_q_held", Q, 32'h55);
        WE = 1'b1; DATA = 32'h77;
        tick();
        WE = 1'b0;
        read_burst(1, 32'h77);
        check("t6_count_end", COUNT, 0);

        // ---------------- RESET mid-burst
        for (int i = 0; i < 3; i++) begin
            WE = 1'b1; DATA = 32'(5000 + i);
            tick();
        end
        RE = 1'b1; DATA = 32'd6000;
        tick();
        #2 RESET = 1'b1;
        #1;
        check("t7_count", COUNT, 0);
        check("t7_flags", {FULL, EMPTY, AFULL, AEMPTY}, 4'b0101);
        check("t7_q", Q, 0);
        check("t7_pulses", {Q_VALID, OVERFLOW, UNDERFLOW}, 3'b000);
        check("t7_ram_reset_n", RAM_RESET_N, 0);
        WE = 1'b0; RE = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        tick();
        check("t7_post_qv0", Q_VALID, 0);
        tick();
        check("t7_post_qv1", Q_VALID, 0);
        check("t7_post_state", {EMPTY, COUNT}, {1'b1, 8'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
